// File: rtl/car_pkg.sv
// Shared definitions for the multi-speed car controller: state encoding,
// steering codes and the default parameter set.
package car_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_IDLE = 2'd1,
      ST_FWD  = 2'd2,
      ST_REV  = 2'd3
   } state_t;

   localparam logic [1:0] STRAIGHT = 2'd0;
   localparam logic [1:0] RIGHT    = 2'd1;
   localparam logic [1:0] LEFT     = 2'd2;

   localparam int DEF_NUM_SPEEDS = 3;
   localparam int DEF_SPD_W      = 3;
   localparam int DEF_ACC_DWELL  = 4;
   localparam int DEF_BLINK_HALF = 8;

   // Code 3 on the steering input is not a direction; fold it onto straight.
   function automatic logic [1:0] steer_map(input logic [1:0] s_in);
      return (s_in == 2'd3) ? STRAIGHT : s_in;
   endfunction

endpackage

// File: rtl/car_ctrl_multispeed_blinker.sv
// Turn indicator: lamp starts ON at restart and toggles every BLINK_HALF
// cycles while enabled; dark and counter cleared when disabled.
module car_blinker
   import car_pkg::*;
#(
   parameter int BLINK_HALF = DEF_BLINK_HALF
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic restart,
   output logic lamp
);

   localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_lamp;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (clr || !en) begin
         r_cnt  <= '0;
         r_lamp <= 1'b0;
      end else if (restart) begin
         r_cnt  <= '0;
         r_lamp <= 1'b1;
      end else if (r_cnt == CW'(BLINK_HALF - 1)) begin
         r_cnt  <= '0;
         r_lamp <= ~r_lamp;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign lamp = r_lamp;

endmodule

// File: rtl/car_ctrl_multispeed.sv
// Engine/speed/steering controller with N forward levels, reverse, an
// acceleration dwell timer, brake step-down and blinking indicators.
module car_ctrl_multispeed
   import car_pkg::*;
#(
   parameter int NUM_SPEEDS = DEF_NUM_SPEEDS,
   parameter int SPD_W      = DEF_SPD_W,
   parameter int ACC_DWELL  = DEF_ACC_DWELL,
   parameter int BLINK_HALF = DEF_BLINK_HALF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             key,
   input  logic             brake,
   input  logic             acc,
   input  logic             rev,
   input  logic [1:0]       s,
   output logic             E,
   output logic [SPD_W-1:0] M1,
   output logic             DIR,
   output logic [1:0]       M2,
   output logic             TL,
   output logic             RH,
   output logic             LH
);

   localparam int DW = (ACC_DWELL > 1) ? $clog2(ACC_DWELL) : 1;

   state_t           r_state, w_state_nxt;
   logic [DW-1:0]    r_dwell, w_dwell_nxt;
   logic [SPD_W-1:0] r_m1, w_m1_nxt;
   logic [1:0]       r_m2, w_m2_nxt;
   logic             r_e, r_dir, r_tl;
   logic             w_acc_ok, w_step, w_restart;

   // Brake always wins over acc; a step fires on the last dwell cycle.
   assign w_acc_ok = acc & ~brake;
   assign w_step   = w_acc_ok && (r_dwell == DW'(ACC_DWELL - 1));

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_m1_nxt    = r_m1;
      w_dwell_nxt = '0;
      if (!key) begin
         w_state_nxt = ST_OFF;
         w_m1_nxt    = '0;
      end else begin
         case (r_state)
            ST_OFF: begin
               w_state_nxt = ST_IDLE;
               w_m1_nxt    = '0;
            end
            ST_IDLE: begin
               if (w_step) begin
                  w_state_nxt = rev ? ST_REV : ST_FWD;
                  w_m1_nxt    = SPD_W'(1);
               end else if (w_acc_ok) begin
                  w_dwell_nxt = r_dwell + DW'(1);
               end
            end
            ST_FWD: begin
               if (brake) begin
                  w_m1_nxt = r_m1 - SPD_W'(1);
                  if (r_m1 <= SPD_W'(1)) begin
                     w_m1_nxt    = '0;
                     w_state_nxt = ST_IDLE;
                  end
               end else if (w_step) begin
                  if (r_m1 < SPD_W'(NUM_SPEEDS)) w_m1_nxt = r_m1 + SPD_W'(1);
               end else if (w_acc_ok) begin
                  w_dwell_nxt = r_dwell + DW'(1);
               end
            end
            ST_REV: begin
               if (brake) begin
                  w_state_nxt = ST_IDLE;
                  w_m1_nxt    = '0;
               end
            end
            default: begin
               w_state_nxt = ST_OFF;
               w_m1_nxt    = '0;
            end
         endcase
      end
   end

   assign w_m2_nxt  = (w_state_nxt != ST_OFF) ? steer_map(s) : STRAIGHT;
   assign w_restart = (w_m2_nxt != r_m2);

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= ST_OFF;
         r_dwell <= '0;
         r_m1    <= '0;
         r_m2    <= STRAIGHT;
         r_e     <= 1'b0;
         r_dir   <= 1'b0;
         r_tl    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dwell <= w_dwell_nxt;
         r_m1    <= w_m1_nxt;
         r_m2    <= w_m2_nxt;
         r_e     <= (w_state_nxt != ST_OFF);
         r_dir   <= (w_state_nxt == ST_REV);
         r_tl    <= r_e & (brake | r_dir);
      end
   end

   car_blinker #(.BLINK_HALF(BLINK_HALF)) u_blink_rh (
      .clk     (clk),
      .clr     (clr),
      .en      (w_m2_nxt == RIGHT),
      .restart (w_restart),
      .lamp    (RH)
   );

   car_blinker #(.BLINK_HALF(BLINK_HALF)) u_blink_lh (
      .clk     (clk),
      .clr     (clr),
      .en      (w_m2_nxt == LEFT),
      .restart (w_restart),
      .lamp    (LH)
   );

   assign E   = r_e;
   assign M1  = r_m1;
   assign DIR = r_dir;
   assign M2  = r_m2;
   assign TL  = r_tl;

endmodule
